// File: rtl/cave_input_ctrl_pkg.sv
// Shared definitions for the Cave input front-end: scancodes, joystick bit positions, player record.
// Joystick-to-player unpacking and the opposing-direction cancel rule live here as helpers.
package cave_input_pkg;

    localparam logic [7:0] SC_P1_UP    = 8'h75;
    localparam logic [7:0] SC_P1_DOWN  = 8'h72;
    localparam logic [7:0] SC_P1_LEFT  = 8'h6B;
    localparam logic [7:0] SC_P1_RIGHT = 8'h74;
    localparam logic [7:0] SC_P1_B1    = 8'h14;
    localparam logic [7:0] SC_P1_B2    = 8'h11;
    localparam logic [7:0] SC_P1_B3    = 8'h29;
    localparam logic [7:0] SC_P1_START = 8'h16;
    localparam logic [7:0] SC_P1_COIN  = 8'h2E;
    localparam logic [7:0] SC_P1_PAUSE = 8'h4D;
    localparam logic [7:0] SC_SVC1     = 8'h46;
    localparam logic [7:0] SC_P2_UP    = 8'h2D;
    localparam logic [7:0] SC_P2_DOWN  = 8'h2B;
    localparam logic [7:0] SC_P2_LEFT  = 8'h23;
    localparam logic [7:0] SC_P2_RIGHT = 8'h34;
    localparam logic [7:0] SC_P2_B1    = 8'h1C;
    localparam logic [7:0] SC_P2_B2    = 8'h1B;
    localparam logic [7:0] SC_P2_B3    = 8'h15;
    localparam logic [7:0] SC_P2_START = 8'h1E;
    localparam logic [7:0] SC_P2_COIN  = 8'h36;
    localparam logic [7:0] SC_SVC2     = 8'h45;

    localparam int JB_RIGHT   = 0;
    localparam int JB_LEFT    = 1;
    localparam int JB_DOWN    = 2;
    localparam int JB_UP      = 3;
    localparam int JB_B1      = 4;
    localparam int JB_B3      = 6;
    localparam int JB_START   = 7;
    localparam int JB_COIN    = 8;
    localparam int JB_PAUSE   = 9;
    localparam int JB_SERVICE = 10;

    typedef struct packed {
        logic [3:0] dir;      // {up, down, left, right}
        logic [2:0] buttons;  // {b3, b2, b1}
        logic       start;
        logic       coin;
        logic       pause;
    } player_t;

    function automatic player_t joy_to_player(input logic [9:0] j);
        player_t p;
        p.dir     = {j[JB_UP], j[JB_DOWN], j[JB_LEFT], j[JB_RIGHT]};
        p.buttons = j[JB_B3:JB_B1];
        p.start   = j[JB_START];
        p.coin    = j[JB_COIN];
        p.pause   = j[JB_PAUSE];
        return p;
    endfunction

    function automatic logic [3:0] socd(input logic [3:0] d, input logic en);
        logic [3:0] r;
        r = d;
        if (en && d[3] && d[2]) r[3:2] = 2'b00;
        if (en && d[1] && d[0]) r[1:0] = 2'b00;
        return r;
    endfunction

endpackage

// File: rtl/cave_coin_stretch.sv
// Turns a coin press edge into a fixed-width pulse; no retrigger while the pulse runs.
// Pulse rises one cycle after the request edge; a soft clear drops it and swallows a same-cycle edge.
module cave_coin_stretch #(
    parameter int COIN_CYCLES = 4_800_000,
    parameter int CNT_W       = 23
) (
    input  logic clk_sys,
    input  logic RESET,
    input  logic clr,
    input  logic req,
    output logic pulse
);
    import cave_input_pkg::*;

    localparam logic [CNT_W-1:0] LOAD = CNT_W'(COIN_CYCLES);

    logic [CNT_W-1:0] cnt;
    logic             req_q;

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            cnt   <= '0;
            req_q <= 1'b0;
            pulse <= 1'b0;
        end else begin
            req_q <= req;
            if (clr) begin
                cnt   <= '0;
                pulse <= 1'b0;
            end else if (cnt == '0) begin
                if (req && !req_q) begin
                    cnt   <= LOAD;
                    pulse <= 1'b1;
                end else begin
                    pulse <= 1'b0;
                end
            end else begin
                // pulse mirrors the post-decrement count so it stays registered
                cnt   <= cnt - 1'b1;
                pulse <= (cnt != CNT_W'(1));
            end
        end
    end

endmodule

// File: rtl/cave_input_ctrl.sv
// PS/2 + joystick merge into per-player controls with coin stretch, pause toggle and SOCD.
// Joystick -> output 1 cycle, PS/2 event -> output 2 cycles (key latch, then output register).
module cave_input_ctrl #(
    parameter int COIN_CYCLES = 4_800_000,
    parameter int CNT_W       = 23
) (
    input  logic        clk_sys,
    input  logic        RESET,
    input  logic        cpu_reset,
    input  logic        socd_en,
    input  logic [10:0] ps2_key,
    input  logic [31:0] joystick_0,
    input  logic [31:0] joystick_1,
    output logic [3:0]  p1_dir,
    output logic [2:0]  p1_buttons,
    output logic        p1_start,
    output logic        p1_coin,
    output logic        p1_pause,
    output logic [3:0]  p2_dir,
    output logic [2:0]  p2_buttons,
    output logic        p2_start,
    output logic        p2_coin,
    output logic        p2_pause,
    output logic [1:0]  service
);
    import cave_input_pkg::*;

    logic       strobe_q;
    logic       key_evt;
    player_t    key1, key2, raw1, raw2;
    logic [1:0] key_svc, raw_svc;
    logic [1:0] pause_prev, pause_q, pause_raw;
    logic       unused_ok;

    assign unused_ok = ^{joystick_0[31:11], joystick_1[31:11], ps2_key[8]};
    assign key_evt   = ps2_key[10] ^ strobe_q;

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            strobe_q <= 1'b0;
            key1     <= '0;
            key2     <= '0;
            key_svc  <= '0;
        end else begin
            strobe_q <= ps2_key[10];
            if (key_evt) begin
                case (ps2_key[7:0])
                    SC_P1_UP:    key1.dir[3]     <= ps2_key[9];
                    SC_P1_DOWN:  key1.dir[2]     <= ps2_key[9];
                    SC_P1_LEFT:  key1.dir[1]     <= ps2_key[9];
                    SC_P1_RIGHT: key1.dir[0]     <= ps2_key[9];
                    SC_P1_B1:    key1.buttons[0] <= ps2_key[9];
                    SC_P1_B2:    key1.buttons[1] <= ps2_key[9];
                    SC_P1_B3:    key1.buttons[2] <= ps2_key[9];
                    SC_P1_START: key1.start      <= ps2_key[9];
                    SC_P1_COIN:  key1.coin       <= ps2_key[9];
                    SC_P1_PAUSE: key1.pause      <= ps2_key[9];
                    SC_SVC1:     key_svc[0]      <= ps2_key[9];
                    SC_P2_UP:    key2.dir[3]     <= ps2_key[9];
                    SC_P2_DOWN:  key2.dir[2]     <= ps2_key[9];
                    SC_P2_LEFT:  key2.dir[1]     <= ps2_key[9];
                    SC_P2_RIGHT: key2.dir[0]     <= ps2_key[9];
                    SC_P2_B1:    key2.buttons[0] <= ps2_key[9];
                    SC_P2_B2:    key2.buttons[1] <= ps2_key[9];
                    SC_P2_B3:    key2.buttons[2] <= ps2_key[9];
                    SC_P2_START: key2.start      <= ps2_key[9];
                    SC_P2_COIN:  key2.coin       <= ps2_key[9];
                    SC_SVC2:     key_svc[1]      <= ps2_key[9];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        raw1      = key1 | joy_to_player(joystick_0[9:0]);
        raw2      = key2 | joy_to_player(joystick_1[9:0]);
        raw_svc   = key_svc | {joystick_1[JB_SERVICE], joystick_0[JB_SERVICE]};
        pause_raw = {raw2.pause, raw1.pause};
    end

    // Soft clear also resyncs the edge history so a same-cycle press is lost.
    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            pause_prev <= '0;
            pause_q    <= '0;
        end else if (cpu_reset) begin
            pause_prev <= pause_raw;
            pause_q    <= '0;
        end else begin
            pause_prev <= pause_raw;
            pause_q    <= pause_q ^ (pause_raw & ~pause_prev);
        end
    end

    assign p1_pause = pause_q[0];
    assign p2_pause = pause_q[1];

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            p1_dir     <= '0;
            p1_buttons <= '0;
            p1_start   <= 1'b0;
            p2_dir     <= '0;
            p2_buttons <= '0;
            p2_start   <= 1'b0;
            service    <= '0;
        end else begin
            p1_dir     <= socd(raw1.dir, socd_en);
            p1_buttons <= raw1.buttons;
            p1_start   <= raw1.start;
            p2_dir     <= socd(raw2.dir, socd_en);
            p2_buttons <= raw2.buttons;
            p2_start   <= raw2.start;
            service    <= raw_svc;
        end
    end

    cave_coin_stretch #(.COIN_CYCLES(COIN_CYCLES), .CNT_W(CNT_W)) u_coin1 (
        .clk_sys (clk_sys),
        .RESET   (RESET),
        .clr     (cpu_reset),
        .req     (raw1.coin),
        .pulse   (p1_coin)
    );

    cave_coin_stretch #(.COIN_CYCLES(COIN_CYCLES), .CNT_W(CNT_W)) u_coin2 (
        .clk_sys (clk_sys),
        .RESET   (RESET),
        .clr     (cpu_reset),
        .req     (raw2.coin),
        .pulse   (p2_coin)
    );

endmodule

// File: tb/tb_cave_input_ctrl.sv
// Directed bench for cave_input_ctrl with a queue of expected values popped at each sample point.
module tb_cave_input_ctrl;

    logic        clk_sys = 1'b0;
    logic        RESET = 1'b1;
    logic        cpu_reset = 1'b0;
    logic        socd_en = 1'b0;
    logic [10:0] ps2_key = '0;
    logic [31:0] joystick_0 = '0;
    logic [31:0] joystick_1 = '0;
    logic [3:0]  p1_dir, p2_dir;
    logic [2:0]  p1_buttons, p2_buttons;
    logic        p1_start, p1_coin, p1_pause, p2_start, p2_coin, p2_pause;
    logic [1:0]  service;
    logic [21:0] outs;
    logic        strobe = 1'b0;
    int          total = 0;
    int          bad = 0;
    int          hi;

    typedef struct {
        string       tag;
        logic [31:0] v;
    } exp_t;
    exp_t sb[$];

    cave_input_ctrl #(.COIN_CYCLES(100), .CNT_W(8)) dut (
        .clk_sys    (clk_sys),
        .RESET      (RESET),
        .cpu_reset  (cpu_reset),
        .socd_en    (socd_en),
        .ps2_key    (ps2_key),
        .joystick_0 (joystick_0),
        .joystick_1 (joystick_1),
        .p1_dir     (p1_dir),
        .p1_buttons (p1_buttons),
        .p1_start   (p1_start),
        .p1_coin    (p1_coin),
        .p1_pause   (p1_pause),
        .p2_dir     (p2_dir),
        .p2_buttons (p2_buttons),
        .p2_start   (p2_start),
        .p2_coin    (p2_coin),
        .p2_pause   (p2_pause),
        .service    (service)
    );

    assign outs = {p1_dir, p1_buttons, p1_start, p1_coin, p1_pause,
                   p2_dir, p2_buttons, p2_start, p2_coin, p2_pause, service};

    always #5 clk_sys = ~clk_sys;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic key(input logic pressed, input logic ext, input logic [7:0] code);
        strobe  = ~strobe;
        ps2_key = {strobe, pressed, ext, code};
    endtask

    task automatic expect_v(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%0h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.v) else begin
                bad++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.v);
            end
        end
    endtask

    initial begin
        // reset state
        #1;
        expect_v("reset_outs", 32'h0);
        check(32'(outs));
        step(2);
        RESET = 1'b0;
        step(1);

        // PS/2 up key: two-cycle latency on press and release
        key(1'b1, 1'b0, 8'h75);
        expect_v("ps2_up_t1", 32'h0);
        expect_v("ps2_up_t2", 32'h8);
        expect_v("ps2_up_hold", 32'h8);
        step(1); check(32'(p1_dir));
        step(1); check(32'(p1_dir));
        step(3); check(32'(p1_dir));
        key(1'b0, 1'b0, 8'h75);
        expect_v("ps2_rel_t1", 32'h8);
        expect_v("ps2_rel_t2", 32'h0);
        step(1); check(32'(p1_dir));
        step(1); check(32'(p1_dir));

        // coin: 10-cycle press gives exactly 100 cycles of pulse from t+1
        joystick_0[8] = 1'b1;
        expect_v("coin_t1", 32'h1);
        expect_v("coin_width", 32'd100);
        expect_v("coin_end", 32'h0);
        step(1);
        check(32'(p1_coin));
        hi = 0;
        for (int i = 0; i < 300; i++) begin
            if (p1_coin) hi++;
            if (i == 9) joystick_0[8] = 1'b0;
            step(1);
        end
        check(32'(hi));
        check(32'(p1_coin));

        // coin held 300 cycles: still a single pulse
        joystick_0[8] = 1'b1;
        expect_v("coin_held_width", 32'd100);
        hi = 0;
        for (int i = 0; i < 300; i++) begin
            step(1);
            if (p1_coin) hi++;
        end
        check(32'(hi));
        joystick_0[8] = 1'b0;
        step(2);

        // pause key toggles on press only
        expect_v("pause_1", 32'h1);
        expect_v("pause_1_rel", 32'h1);
        expect_v("pause_0", 32'h0);
        expect_v("pause_0_rel", 32'h0);
        key(1'b1, 1'b0, 8'h4D); step(2); check(32'(p1_pause));
        key(1'b0, 1'b0, 8'h4D); step(2); check(32'(p1_pause));
        key(1'b1, 1'b0, 8'h4D); step(2); check(32'(p1_pause));
        key(1'b0, 1'b0, 8'h4D); step(2); check(32'(p1_pause));
        key(1'b1, 1'b0, 8'h4D); key(1'b0, 1'b0, 8'h4D);
        key(1'b1, 1'b0, 8'h4D); step(2);
        key(1'b0, 1'b0, 8'h4D); step(2);
        expect_v("pause_before_cpu_reset", 32'h1);
        check(32'(p1_pause));
        cpu_reset = 1'b1;
        expect_v("pause_cpu_reset", 32'h0);
        step(1); check(32'(p1_pause));
        cpu_reset = 1'b0;

        // held joystick pause toggles once
        joystick_0[9] = 1'b1;
        expect_v("pause_held", 32'h1);
        step(5); check(32'(p1_pause));
        joystick_0[9] = 1'b0;
        step(2);

        // cpu_reset wins over a same-cycle pause edge and the edge is lost
        joystick_0[9] = 1'b1;
        cpu_reset = 1'b1;
        expect_v("pause_edge_vs_clr", 32'h0);
        expect_v("pause_edge_discarded", 32'h0);
        step(1); check(32'(p1_pause));
        cpu_reset = 1'b0;
        step(3); check(32'(p1_pause));
        joystick_0[9] = 1'b0;
        step(2);

        // same for coin
        joystick_0[8] = 1'b1;
        cpu_reset = 1'b1;
        expect_v("coin_edge_vs_clr", 32'h0);
        expect_v("coin_edge_discarded", 32'h0);
        step(1); check(32'(p1_coin));
        cpu_reset = 1'b0;
        step(3); check(32'(p1_coin));
        joystick_0[8] = 1'b0;
        step(1);

        // SOCD
        socd_en = 1'b1;
        joystick_1[3:1] = 3'b111;
        expect_v("socd_ud", 32'h2);
        step(1); check(32'(p2_dir));
        socd_en = 1'b0;
        expect_v("socd_off", 32'hE);
        step(1); check(32'(p2_dir));
        socd_en = 1'b1;
        joystick_1[3:0] = 4'b1011;
        expect_v("socd_lr", 32'h8);
        step(1); check(32'(p2_dir));
        joystick_1 = '0;
        socd_en = 1'b0;

        // key event and joystick change in the same cycle, plus service OR
        key(1'b1, 1'b0, 8'h29);
        joystick_0[4] = 1'b1;
        expect_v("btn_joy_first", 32'h1);
        expect_v("btn_both", 32'h5);
        step(1); check(32'(p1_buttons));
        step(1); check(32'(p1_buttons));
        joystick_1[10] = 1'b1;
        key(1'b1, 1'b0, 8'h46);
        expect_v("service_both", 32'h3);
        step(2); check(32'(service));
        key(1'b0, 1'b0, 8'h29); step(2);
        key(1'b0, 1'b0, 8'h46); step(2);
        joystick_0 = '0;
        joystick_1 = '0;
        expect_v("all_clear", 32'h0);
        step(1); check(32'(outs));

        // extended bit ignored; unmapped code changes nothing
        key(1'b1, 1'b1, 8'h2D);
        expect_v("p2_up_ext", 32'h800);
        step(2); check(32'(outs));
        key(1'b1, 1'b0, 8'h5A);
        for (int i = 0; i < 4; i++) begin
            expect_v("unmapped_hold", 32'h800);
            step(1);
            check(32'(outs));
        end

        // async reset mid pulse with key held
        joystick_1[8] = 1'b1;
        expect_v("p2_coin_mid", 32'h1);
        step(21); check(32'(p2_coin));
        #2;
        RESET = 1'b1;
        joystick_1 = '0;
        ps2_key = '0;
        strobe = 1'b0;
        #1;
        expect_v("async_reset_outs", 32'h0);
        check(32'(outs));
        @(posedge clk_sys);
        #1;
        RESET = 1'b0;
        hi = 0;
        for (int i = 0; i < 150; i++) begin
            step(1);
            if (p2_coin) hi++;
        end
        expect_v("no_pulse_after_reset", 32'h0);
        expect_v("outs_after_reset", 32'h0);
        check(32'(hi));
        check(32'(outs));
        joystick_1[8] = 1'b1;
        expect_v("new_coin_after_reset", 32'h1);
        step(1); check(32'(p2_coin));
        joystick_1 = '0;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
